// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants, state type and sizing helper for mem_decoder
//
// Purpose: single place for the slave index assignment, the base/mask windows
// of each peripheral and the decoder state type.
// Ports: none (package).
package mem_map_pkg;

  localparam int SLAVE_LEDS  = 0;
  localparam int SLAVE_UART  = 1;
  localparam int SLAVE_TIMER = 2;
  localparam int SLAVE_FLASH = 3;
  localparam int SLAVE_RAM   = 4;

  localparam logic [31:0] LEDS_BASE  = 32'h0001_0000;
  localparam logic [31:0] LEDS_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] UART_BASE  = 32'h0002_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER_BASE = 32'h0003_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] FLASH_BASE = 32'h0100_0000;
  localparam logic [31:0] FLASH_MASK = 32'hFF00_0000;
  localparam logic [31:0] RAM_BASE   = 32'h1000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFF00_0000;

  localparam int MAP_SLAVES = 5;

  // Packed so that slave i sits at bits [32i+31:32i].
  localparam logic [MAP_SLAVES*32-1:0] MAP_BASE =
    {RAM_BASE, FLASH_BASE, TIMER_BASE, UART_BASE, LEDS_BASE};
  localparam logic [MAP_SLAVES*32-1:0] MAP_MASK =
    {RAM_MASK, FLASH_MASK, TIMER_MASK, UART_MASK, LEDS_MASK};

  typedef enum logic {IDLE, WAIT} state_t;

  // Wait-counter width: enough to hold TIMEOUT, never narrower than one bit.
  function automatic int ctr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_decoder_if.sv
// rtl/mem_decoder_if.sv - master-side bus of the memory decoder
//
// Purpose: groups the request/response signals between the bus arbiter and
// the decoder.
// Signals: address_in, read_in, write_in (master -> decoder);
//          read_value_out, ready_out, fault_out (decoder -> master).
interface mem_decoder_if;
  logic [31:0] address_in;
  logic        read_in;
  logic        write_in;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        fault_out;

  modport master (
    output address_in, read_in, write_in,
    input  read_value_out, ready_out, fault_out
  );

  modport slave (
    input  address_in, read_in, write_in,
    output read_value_out, ready_out, fault_out
  );
endinterface

// File: rtl/addr_match.sv
// rtl/addr_match.sv - masked address window comparator
//
// Purpose: flags an address that falls inside one slave window.
// Ports: address, base, mask (in, 32 each); match (out, 1).
module addr_match (
  input  logic [31:0] address,
  input  logic [31:0] base,
  input  logic [31:0] mask,
  output logic        match
);
  assign match = ((address & mask) == base);
endmodule

// File: rtl/mem_decoder.sv
// rtl/mem_decoder.sv - parametrised address decoder, response mux and slave timeout
//
// Purpose: selects one slave per request, muxes its read data and ready back
// to the master, faults unmapped addresses and slaves that stall too long,
// and records the last fault address and a saturating fault count.
// Ports: clk, reset (sync, active-high); bus (master request/response);
//        sel_out (one-hot select); slave_read_value_in, slave_ready_in
//        (per-slave response); fault_clear_in; fault_address_out;
//        fault_count_out.
module mem_decoder
  import mem_map_pkg::*;
#(
  parameter int                         NUM_SLAVES = MAP_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = MAP_BASE,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = MAP_MASK,
  parameter int                         TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_decoder_if.slave             bus,
  output logic [NUM_SLAVES-1:0]    sel_out,
  input  logic [NUM_SLAVES*32-1:0] slave_read_value_in,
  input  logic [NUM_SLAVES-1:0]    slave_ready_in,
  input  logic                     fault_clear_in,
  output logic [31:0]              fault_address_out,
  output logic [7:0]               fault_count_out
);

  localparam int            CW    = ctr_width(TIMEOUT);
  localparam int            IW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [NUM_SLAVES-1:0] hit;
  logic [31:0]           slave_rv [NUM_SLAVES];
  logic [IW-1:0]         sel_idx;
  logic                  mapped;
  logic                  req;
  logic                  active;
  logic                  sel_ready;
  logic                  timeout_hit;
  logic                  fault;
  state_t                state;
  logic [CW-1:0]         count;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
    addr_match u_match (
      .address (bus.address_in),
      .base    (SLAVE_BASE[32*i +: 32]),
      .mask    (SLAVE_MASK[32*i +: 32]),
      .match   (hit[i])
    );
    assign slave_rv[i] = slave_read_value_in[32*i +: 32];
  end

  // Priority encoder: scanning downwards lets the lowest matching index win.
  always_comb begin
    sel_idx = '0;
    mapped  = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_idx = IW'(i);
        mapped  = 1'b1;
      end
    end
  end

  assign req       = bus.read_in | bus.write_in;
  assign active    = req & mapped & ~reset;
  assign sel_ready = active & slave_ready_in[sel_idx];

  // A ready arriving in the expiry cycle takes precedence over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && active && (state == WAIT) &&
                       (count == LIMIT) && !sel_ready;
  assign fault       = (req & ~mapped & ~reset) | timeout_hit;

  assign sel_out            = active ? (NUM_SLAVES'(1) << sel_idx) : '0;
  assign bus.ready_out      = fault | sel_ready;
  assign bus.fault_out      = fault;
  assign bus.read_value_out = (active && !fault) ? slave_rv[sel_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      fault_address_out <= 32'h0;
      fault_count_out   <= 8'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (active && !sel_ready) begin
            state <= WAIT;
            count <= CW'(1);
          end else begin
            count <= '0;
          end
        end
        WAIT: begin
          // Dropping the request mid-wait abandons it silently.
          if (!active || sel_ready || timeout_hit) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
      endcase

      // A fault in the clear cycle is recorded as the first fault after clear.
      if (fault) begin
        fault_address_out <= bus.address_in;
        if (fault_clear_in) begin
          fault_count_out <= 8'd1;
        end else if (fault_count_out != 8'hFF) begin
          fault_count_out <= fault_count_out + 8'd1;
        end
      end else if (fault_clear_in) begin
        fault_address_out <= 32'h0;
        fault_count_out   <= 8'h0;
      end
    end
  end

endmodule
